mux_n_reg: RTL and testbench

//  Parametrised N:1, W-bit multiplexer with a registered valid/ready output stage.

---
 rtl/mux_n_pkg.sv | 5 +
 rtl/mux_n_reg_rr_pick.sv | 33 +++
 rtl/mux_n_reg.sv | 116 +++++++++++
 tb/tb_mux_n_reg.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_pkg.sv
// Shared constants for mux_n_reg: selection-mode encodings.
package mux_n_pkg;
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;
endpackage

// File: rtl/mux_n_reg_rr_pick.sv
// Rotating-priority picker: first asserted req searching from ptr+1 and wrapping to ptr.
// Purely combinational; the caller owns the pointer register.
module rr_pick
    import mux_n_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin : p_pick
        int w_c;
        w_c     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        // ptr < N and k <= N, so a single conditional subtract replaces a modulo
        for (int k = 1; k <= N; k++) begin
            w_c = int'(ptr) + k;
            if (w_c >= N) begin
                w_c = w_c - N;
            end
            if (!gnt_any && req[w_c]) begin
                gnt_any = 1'b1;
                gnt_idx = SW'(w_c);
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// N:1 W-bit mux with registered valid/ready output; 1-cycle latency, full throughput under out_ready.
// Optional MUX_N_REG_COUNT_EN adds a 16-bit wrapping output-handshake counter xfer_cnt.
module mux_n_reg
    import mux_n_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_SEL,
    parameter int SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
`ifdef MUX_N_REG_COUNT_EN
    ,
    output logic [15:0]     xfer_cnt
`endif
);

    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic [SW-1:0]   r_out_ch;
    logic            w_can_load;
    logic            w_gnt_any;
    logic            w_port_en;
    logic [SW-1:0]   w_gnt_idx;
    logic            w_xfer;
    logic [W-1:0]    w_word;

    assign w_can_load = !r_out_valid || out_ready;
    assign w_xfer     = w_gnt_any && w_can_load;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SW-1:0] r_ptr;
            logic [SW-1:0] w_idx;
            logic          w_any;

            rr_pick #(.N(N), .SW(SW)) u_pick (
                .req     (in_valid),
                .ptr     (r_ptr),
                .gnt_idx (w_idx),
                .gnt_any (w_any)
            );

            // Reset to N-1 so channel 0 is first in line after reset
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= SW'(N - 1);
                end else if (w_xfer) begin
                    r_ptr <= w_idx;
                end
            end

            assign w_gnt_idx = w_idx;
            assign w_gnt_any = w_any;
            assign w_port_en = w_any;
        end else begin : g_sel
            logic w_sel_ok;
            // Ready follows sel alone so it never depends on the same channel's valid
            assign w_sel_ok  = int'(sel) < N;
            assign w_gnt_idx = sel;
            assign w_port_en = w_sel_ok;
            assign w_gnt_any = w_sel_ok && in_valid[sel];
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        if (w_port_en && w_can_load) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_word = in_data[int'(w_gnt_idx)*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_ch    <= w_gnt_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

`ifdef MUX_N_REG_COUNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Three instances (N4 select, N4 round-robin, N3 select) driven in parallel against a cycle model.
module tb_mux_n_reg;

    logic       clk;
    logic       rst;
    logic [3:0] s_vld [3];
    logic [7:0] s_dat [3][4];
    logic [1:0] s_sel [3];
    logic       s_ordy [3];

    logic [3:0] w_rdy0, w_rdy1;
    logic [2:0] w_rdy2;
    logic [7:0] w_dat0, w_dat1, w_dat2;
    logic       w_vld0, w_vld1, w_vld2;
    logic [1:0] w_ch0, w_ch1, w_ch2;
`ifdef MUX_N_REG_COUNT_EN
    logic [15:0] w_cnt0, w_cnt1, w_cnt2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    bit         m_vld [3];
    logic [7:0] m_dat [3];
    int         m_ch  [3];
    int         m_ptr [3];
    logic [15:0] m_cnt [3];
    bit         nx_vld [3];
    logic [7:0] nx_dat [3];
    int         nx_ch  [3];
    int         nx_ptr [3];
    logic [15:0] nx_cnt [3];

    mux_n_reg #(.N(4), .W(8), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data({s_dat[0][3], s_dat[0][2], s_dat[0][1], s_dat[0][0]}),
        .in_valid(s_vld[0]), .in_ready(w_rdy0), .sel(s_sel[0]),
        .out_data(w_dat0), .out_valid(w_vld0), .out_ready(s_ordy[0]), .out_ch(w_ch0)
`ifdef MUX_N_REG_COUNT_EN
        , .xfer_cnt(w_cnt0)
`endif
    );

    mux_n_reg #(.N(4), .W(8), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data({s_dat[1][3], s_dat[1][2], s_dat[1][1], s_dat[1][0]}),
        .in_valid(s_vld[1]), .in_ready(w_rdy1), .sel(s_sel[1]),
        .out_data(w_dat1), .out_valid(w_vld1), .out_ready(s_ordy[1]), .out_ch(w_ch1)
`ifdef MUX_N_REG_COUNT_EN
        , .xfer_cnt(w_cnt1)
`endif
    );

    mux_n_reg #(.N(3), .W(8), .MODE(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_data({s_dat[2][2], s_dat[2][1], s_dat[2][0]}),
        .in_valid(s_vld[2][2:0]), .in_ready(w_rdy2), .sel(s_sel[2]),
        .out_data(w_dat2), .out_valid(w_vld2), .out_ready(s_ordy[2]), .out_ch(w_ch2)
`ifdef MUX_N_REG_COUNT_EN
        , .xfer_cnt(w_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_rdy(input int d);
        case (d)
            0:       return 32'(w_rdy0);
            1:       return 32'(w_rdy1);
            default: return 32'(w_rdy2);
        endcase
    endfunction

    function automatic logic [31:0] get_vld(input int d);
        case (d)
            0:       return 32'(w_vld0);
            1:       return 32'(w_vld1);
            default: return 32'(w_vld2);
        endcase
    endfunction

    function automatic logic [31:0] get_dat(input int d);
        case (d)
            0:       return 32'(w_dat0);
            1:       return 32'(w_dat1);
            default: return 32'(w_dat2);
        endcase
    endfunction

    function automatic logic [31:0] get_ch(input int d);
        case (d)
            0:       return 32'(w_ch0);
            1:       return 32'(w_ch1);
            default: return 32'(w_ch2);
        endcase
    endfunction

`ifdef MUX_N_REG_COUNT_EN
    function automatic logic [31:0] get_cnt(input int d);
        case (d)
            0:       return 32'(w_cnt0);
            1:       return 32'(w_cnt1);
            default: return 32'(w_cnt2);
        endcase
    endfunction
`endif

    // Evaluate grant rules on settled inputs, check in_ready, and predict the next state
    task automatic model_eval();
        for (int d = 0; d < 3; d++) begin
            int n;
            int g;
            bit has;
            bit port;
            bit can;
            logic [31:0] er;
            n    = (d == 2) ? 3 : 4;
            g    = 0;
            has  = 0;
            port = 0;
            if (d != 1) begin
                if (int'(s_sel[d]) < n) begin
                    port = 1;
                    g    = int'(s_sel[d]);
                    has  = s_vld[d][g];
                end
            end else begin
                for (int k = 1; k <= n; k++) begin
                    int c;
                    c = (m_ptr[d] + k) % n;
                    if (!has && s_vld[d][c]) begin
                        has = 1;
                        g   = c;
                    end
                end
                port = has;
            end
            can = !m_vld[d] || s_ordy[d];
            er  = (port && can) ? (32'd1 << g) : 32'd0;
            if (chk_en) chk($sformatf("d%0d_in_ready", d), get_rdy(d), er);

            nx_vld[d] = m_vld[d];
            nx_dat[d] = m_dat[d];
            nx_ch[d]  = m_ch[d];
            nx_ptr[d] = m_ptr[d];
            nx_cnt[d] = m_cnt[d];
            if (rst) begin
                nx_vld[d] = 0;
                nx_dat[d] = '0;
                nx_ch[d]  = 0;
                nx_ptr[d] = n - 1;
                nx_cnt[d] = '0;
            end else begin
                if (m_vld[d] && s_ordy[d]) nx_cnt[d] = m_cnt[d] + 16'd1;
                if (has && can) begin
                    nx_vld[d] = 1;
                    nx_dat[d] = s_dat[d][g];
                    nx_ch[d]  = g;
                    nx_ptr[d] = g;
                end else if (s_ordy[d]) begin
                    nx_vld[d] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            m_vld[d] = nx_vld[d];
            m_dat[d] = nx_dat[d];
            m_ch[d]  = nx_ch[d];
            m_ptr[d] = nx_ptr[d];
            m_cnt[d] = nx_cnt[d];
            chk($sformatf("d%0d_out_valid", d), get_vld(d), 32'(m_vld[d]));
            chk($sformatf("d%0d_out_data", d), get_dat(d), 32'(m_dat[d]));
            chk($sformatf("d%0d_out_ch", d), get_ch(d), 32'(m_ch[d]));
`ifdef MUX_N_REG_COUNT_EN
            chk($sformatf("d%0d_xfer_cnt", d), get_cnt(d), 32'(m_cnt[d]));
`endif
        end
        chk_en = 1;
    endtask

    task automatic rand_all(input int ordy_pct);
        for (int d = 0; d < 3; d++) begin
            s_vld[d]  = 4'($urandom);
            s_sel[d]  = 2'($urandom);
            s_ordy[d] = ($urandom_range(0, 99) < ordy_pct);
            for (int j = 0; j < 4; j++) s_dat[d][j] = 8'($urandom);
        end
    endtask

    initial begin
        int exp_rr[6];
        rst = 1'b1;
        rand_all(50);
        tick();
        tick();
        chk("rst_out_valid", 32'(w_vld1), 32'd0);
        chk("rst_out_ch", 32'(w_ch1), 32'd0);
        rst = 1'b0;

        // Directed: d0 select load, d1 RR with all valid, d2 select out of range
        rand_all(50);
        s_sel[0] = 2'd2; s_vld[0] = 4'b0100; s_dat[0][2] = 8'hA5; s_ordy[0] = 1'b1;
        s_vld[1] = 4'b1111; s_ordy[1] = 1'b1;
        s_sel[2] = 2'd3; s_vld[2] = 4'b0111; s_ordy[2] = 1'b1;
        #1;
        chk("t1_in_ready", 32'(w_rdy0), 32'h4);
        chk("t5_in_ready", 32'(w_rdy2), 32'h0);
        tick();
        chk("t1_out_data", 32'(w_dat0), 32'hA5);
        chk("t1_out_ch", 32'(w_ch0), 32'd2);
        chk("t3_ch_0", 32'(w_ch1), 32'd0);

        for (int i = 0; i < 3; i++) begin
            s_ordy[0] = 1'b0;
            s_sel[0]  = 2'($urandom);
            s_vld[0]  = 4'($urandom);
            s_dat[0][0] = 8'($urandom); s_dat[0][1] = 8'($urandom);
            s_dat[0][2] = 8'($urandom); s_dat[0][3] = 8'($urandom);
            #1;
            chk("t2_in_ready_stall", 32'(w_rdy0), 32'h0);
            tick();
            chk("t2_held_data", 32'(w_dat0), 32'hA5);
            chk("t2_held_ch", 32'(w_ch0), 32'd2);
            chk($sformatf("t3_ch_%0d", i + 1), 32'(w_ch1), 32'(i + 1));
            chk("t5_out_valid", 32'(w_vld2), 32'd0);
        end
        s_ordy[0] = 1'b1; s_sel[0] = 2'd1; s_vld[0] = 4'b0010; s_dat[0][1] = 8'h5A;
        tick();
        chk("t2_new_data", 32'(w_dat0), 32'h5A);
        chk("t3_ch_wrap", 32'(w_ch1), 32'd0);

        // RR with only ch0/ch3 requesting, including a two-cycle stall
        exp_rr = '{3, 0, 3, 3, 3, 0};
        for (int i = 0; i < 6; i++) begin
            rand_all(50);
            s_vld[1]  = 4'b1001;
            s_ordy[1] = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("t4_ch_%0d", i), 32'(w_ch1), 32'(exp_rr[i]));
        end

        for (int i = 0; i < 1500; i++) begin
            rand_all(70);
            tick();
        end

        // Reset while loaded and handshaking on every instance
        rand_all(50);
        for (int d = 0; d < 3; d++) begin
            s_vld[d] = 4'hF; s_sel[d] = 2'd0; s_ordy[d] = 1'b1;
        end
        tick();
        rst = 1'b1;
        tick();
        chk("t6_vld0", 32'(w_vld0), 32'd0);
        chk("t6_vld1", 32'(w_vld1), 32'd0);
        chk("t6_ch1", 32'(w_ch1), 32'd0);
        rst = 1'b0;
        rand_all(50);
        s_vld[1] = 4'hF; s_ordy[1] = 1'b1;
        tick();
        chk("t6_rr_restart", 32'(w_ch1), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            rand_all(70);
            tick();
        end

`ifdef MUX_N_REG_COUNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            rand_all(50);
            s_vld[0] = 4'hF; s_sel[0] = 2'd0; s_ordy[0] = 1'b1;
            tick();
        end
        chk("cnt_wrap", 32'(w_cnt0), 32'd0);
        rst = 1'b1;
        tick();
        chk("cnt_rst", 32'(w_cnt1), 32'd0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
